pipeline_exe: RTL and testbench

//  Execute stage of the five-stage RV32IM MCU pipeline, between decode and memory.

---
 rtl/pipeline_exe.sv | 142 ++++++++++++++
 tb/tb_pipeline_exe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exe.sv
// Execute stage of the RV32IM pipeline: one-hot selected ALU/MUL/DIV result plus
// the decode control fields, all registered into the EXE/MEM pipeline register.
module pipeline_exe (
  input  logic        clk,
  input  logic        resetn,
  input  logic [17:0] alu_op_d_i,
  input  logic [31:0] rs1_d_i,
  input  logic [31:0] rs2_d_i,
  input  logic [31:0] extended_imm_d_i,
  input  logic [31:0] pc_plus4_d_i,
  input  logic [2:0]  dmem_type_d_i,
  input  logic        reg_write_en_d_i,
  input  logic [4:0]  rd_idx_d_i,
  input  logic [3:0]  result_src_d_i,
  input  logic        instr_illegal_d_i,
  output logic [31:0] alu_result_e_o,
  output logic [2:0]  dmem_type_e_o,
  output logic [31:0] extended_imm_e_o,
  output logic [31:0] pc_plus4_e_o,
  output logic        reg_write_en_e_o,
  output logic [4:0]  rd_idx_e_o,
  output logic [3:0]  result_src_e_o,
  output logic        instr_illegal_e_o
);

  localparam logic [17:0] OP_ADD    = 18'h00001;
  localparam logic [17:0] OP_SUB    = 18'h00002;
  localparam logic [17:0] OP_SLL    = 18'h00004;
  localparam logic [17:0] OP_SLT    = 18'h00008;
  localparam logic [17:0] OP_SLTU   = 18'h00010;
  localparam logic [17:0] OP_XOR    = 18'h00020;
  localparam logic [17:0] OP_SRL    = 18'h00040;
  localparam logic [17:0] OP_SRA    = 18'h00080;
  localparam logic [17:0] OP_OR     = 18'h00100;
  localparam logic [17:0] OP_AND    = 18'h00200;
  localparam logic [17:0] OP_MUL    = 18'h00400;
  localparam logic [17:0] OP_MULH   = 18'h00800;
  localparam logic [17:0] OP_MULHSU = 18'h01000;
  localparam logic [17:0] OP_MULHU  = 18'h02000;
  localparam logic [17:0] OP_DIV    = 18'h04000;
  localparam logic [17:0] OP_DIVU   = 18'h08000;
  localparam logic [17:0] OP_REM    = 18'h10000;
  localparam logic [17:0] OP_REMU   = 18'h20000;

  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shamt;

  assign a     = rs1_d_i;
  assign b     = rs2_d_i;
  assign shamt = b[4:0];

  // One shared 64-bit multiplier; the MULH variants differ only in operand sign extension.
  logic        mul_a_signed;
  logic        mul_b_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  assign mul_a_signed = alu_op_d_i[11] | alu_op_d_i[12];
  assign mul_b_signed = alu_op_d_i[11];
  assign mul_a        = {{32{mul_a_signed & a[31]}}, a};
  assign mul_b        = {{32{mul_b_signed & b[31]}}, b};
  assign product      = mul_a * mul_b;

  // Signed division runs on magnitudes; the overflow case falls out naturally.
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign div_signed = alu_op_d_i[14] | alu_op_d_i[16];
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign a_mag      = a_neg ? (32'd0 - a) : a;
  assign b_mag      = b_neg ? (32'd0 - b) : b;
  assign div_zero   = (b == 32'd0);
  assign quot_mag   = div_zero ? 32'd0 : (a_mag / b_mag);
  assign rem_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
  assign quot       = div_zero ? 32'hFFFF_FFFF
                    : ((a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag);
  assign rem        = div_zero ? a : (a_neg ? (32'd0 - rem_mag) : rem_mag);

  logic [31:0] result;

  // NOTE: default assignment first so no path through the case can infer a latch.
  always_comb begin
    result = 32'd0;
    case (alu_op_d_i)
      OP_ADD:    result = a + b;
      OP_SUB:    result = a - b;
      OP_SLL:    result = a << shamt;
      OP_SLT:    result = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU:   result = {31'd0, (a < b)};
      OP_XOR:    result = a ^ b;
      OP_SRL:    result = a >> shamt;
      OP_SRA:    result = $signed(a) >>> shamt;
      OP_OR:     result = a | b;
      OP_AND:    result = a & b;
      OP_MUL:    result = product[31:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  result = product[63:32];
      OP_DIV,
      OP_DIVU:   result = quot;
      OP_REM,
      OP_REMU:   result = rem;
      default:   result = 32'd0;
    endcase
  end

  // NOTE: resetn is sampled inside the clocked block (synchronous), and every
  // flop uses non-blocking assignment so all fields update together at the edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_result_e_o    <= '0;
      dmem_type_e_o     <= '0;
      extended_imm_e_o  <= '0;
      pc_plus4_e_o      <= '0;
      reg_write_en_e_o  <= 1'b0;
      rd_idx_e_o        <= '0;
      result_src_e_o    <= '0;
      instr_illegal_e_o <= 1'b0;
    end else begin
      alu_result_e_o    <= result;
      dmem_type_e_o     <= dmem_type_d_i;
      extended_imm_e_o  <= extended_imm_d_i;
      pc_plus4_e_o      <= pc_plus4_d_i;
      reg_write_en_e_o  <= reg_write_en_d_i & ~instr_illegal_d_i;
      rd_idx_e_o        <= rd_idx_d_i;
      result_src_e_o    <= result_src_d_i;
      instr_illegal_e_o <= instr_illegal_d_i;
    end
  end

endmodule

// File: tb/tb_pipeline_exe.sv
// Scoreboard bench for pipeline_exe: each driven operation pushes its expected
// registered outputs, which are popped and compared one cycle later.
module tb_pipeline_exe;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  dmem;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic        we;
    logic [4:0]  rd;
    logic [3:0]  src;
    logic        ill;
  } out_t;

  typedef struct {
    out_t  o;
    string name;
  } sb_entry_t;

  logic        clk;
  logic        resetn;
  logic [17:0] alu_op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] ext_imm;
  logic [31:0] pc_plus4;
  logic [2:0]  dmem_type;
  logic        reg_write_en;
  logic [4:0]  rd_idx;
  logic [3:0]  result_src;
  logic        instr_illegal;

  logic [31:0] alu_result_e;
  logic [2:0]  dmem_type_e;
  logic [31:0] extended_imm_e;
  logic [31:0] pc_plus4_e;
  logic        reg_write_en_e;
  logic [4:0]  rd_idx_e;
  logic [3:0]  result_src_e;
  logic        instr_illegal_e;

  int checks = 0;
  int errors = 0;
  sb_entry_t sb_q[$];

  pipeline_exe dut (
    .clk               (clk),
    .resetn            (resetn),
    .alu_op_d_i        (alu_op),
    .rs1_d_i           (rs1),
    .rs2_d_i           (rs2),
    .extended_imm_d_i  (ext_imm),
    .pc_plus4_d_i      (pc_plus4),
    .dmem_type_d_i     (dmem_type),
    .reg_write_en_d_i  (reg_write_en),
    .rd_idx_d_i        (rd_idx),
    .result_src_d_i    (result_src),
    .instr_illegal_d_i (instr_illegal),
    .alu_result_e_o    (alu_result_e),
    .dmem_type_e_o     (dmem_type_e),
    .extended_imm_e_o  (extended_imm_e),
    .pc_plus4_e_o      (pc_plus4_e),
    .reg_write_en_e_o  (reg_write_en_e),
    .rd_idx_e_o        (rd_idx_e),
    .result_src_e_o    (result_src_e),
    .instr_illegal_e_o (instr_illegal_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t observe();
    out_t o;
    o.res  = alu_result_e;
    o.dmem = dmem_type_e;
    o.imm  = extended_imm_e;
    o.pc4  = pc_plus4_e;
    o.we   = reg_write_en_e;
    o.rd   = rd_idx_e;
    o.src  = result_src_e;
    o.ill  = instr_illegal_e;
    return o;
  endfunction

  // Reference model: decode the one-hot select to an index, then use wide
  // behavioural arithmetic with the RISC-V corner cases spelled out.
  function automatic logic [31:0] alu_model(input logic [17:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int idx;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    logic [63:0]        up;
    logic [31:0]        r;
    if ($countones(op) != 1) return 32'd0;
    idx = 0;
    for (int i = 0; i < 18; i++) if (op[i]) idx = i;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = 32'd0;
    case (idx)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a << b[4:0];
      3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4:  r = (a < b) ? 32'd1 : 32'd0;
      5:  r = a ^ b;
      6:  r = a >> b[4:0];
      7:  r = $signed(a) >>> b[4:0];
      8:  r = a | b;
      9:  r = a & b;
      10: begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
      11: begin p = sa * sb; r = p[63:32]; end
      12: begin p = sa * $signed({32'd0, b}); r = p[63:32]; end
      13: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
      14: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      15: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      16: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      17: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // One pipeline beat: compare the head of the scoreboard, then drive and enqueue.
  task automatic step(input string name, input logic rst, input logic [17:0] op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic we, input logic ill,
                      input logic [4:0] rd);
    sb_entry_t e;
    out_t      got;
    @(negedge clk);
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      got = observe();
      checks++;
      if (got !== e.o) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.name, got, e.o);
      end
    end
    resetn        = rst;
    alu_op        = op;
    rs1           = a;
    rs2           = b;
    ext_imm       = $urandom;
    pc_plus4      = $urandom;
    dmem_type     = 3'($urandom_range(7, 0));
    result_src    = 4'($urandom_range(15, 0));
    reg_write_en  = we;
    instr_illegal = ill;
    rd_idx        = rd;
    e.name  = name;
    e.o.res  = res;
    e.o.dmem = dmem_type;
    e.o.imm  = ext_imm;
    e.o.pc4  = pc_plus4;
    e.o.we   = we & ~ill;
    e.o.rd   = rd;
    e.o.src  = result_src;
    e.o.ill  = ill;
    if (!rst) e.o = '0;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    alu_op        = 18'h00001;
    rs1           = 32'h1234_5678;
    rs2           = 32'h1111_1111;
    ext_imm       = 32'hDEAD_BEEF;
    pc_plus4      = 32'h0000_1004;
    dmem_type     = 3'd5;
    reg_write_en  = 1'b1;
    rd_idx        = 5'd9;
    result_src    = 4'd3;
    instr_illegal = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (observe() !== '0) begin
      errors++;
      $display("FAIL reset_state: observed %h expected all zero", observe());
    end
  endtask

  task automatic test_add_sub();
    step("add_wrap", 1'b1, 18'h00001, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 5'd1);
    step("sub_wrap", 1'b1, 18'h00002, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd2);
  endtask

  task automatic test_shift_compare();
    step("sra",  1'b1, 18'h00080, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b1, 1'b0, 5'd3);
    step("srl",  1'b1, 18'h00040, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b1, 1'b0, 5'd4);
    step("sll",  1'b1, 18'h00004, 32'd1, 32'h3F, 32'h8000_0000, 1'b1, 1'b0, 5'd5);
    step("slt",  1'b1, 18'h00008, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b0, 5'd6);
    step("sltu", 1'b1, 18'h00010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 5'd7);
  endtask

  task automatic test_mul();
    step("mulh",   1'b1, 18'h00800, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 1'b0, 5'd8);
    step("mulhu",  1'b1, 18'h02000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1, 1'b0, 5'd9);
    step("mul",    1'b1, 18'h00400, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 5'd10);
    step("mulhsu", 1'b1, 18'h01000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd11);
  endtask

  task automatic test_div();
    step("div_by_zero",  1'b1, 18'h04000, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd12);
    step("rem_by_zero",  1'b1, 18'h10000, 32'd7, 32'd0, 32'd7, 1'b1, 1'b0, 5'd13);
    step("divu_by_zero", 1'b1, 18'h08000, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd14);
    step("remu_by_zero", 1'b1, 18'h20000, 32'd7, 32'd0, 32'd7, 1'b1, 1'b0, 5'd15);
    step("div_overflow", 1'b1, 18'h04000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 5'd16);
    step("rem_overflow", 1'b1, 18'h10000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 5'd17);
    step("div_neg",      1'b1, 18'h04000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, 1'b0, 5'd18);
    step("rem_neg",      1'b1, 18'h10000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd19);
  endtask

  task automatic test_invalid_op();
    step("op_zero",     1'b1, 18'h00000, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0, 5'd20);
    step("op_multihot", 1'b1, 18'h00003, 32'd5, 32'd3, 32'd0, 1'b1, 1'b0, 5'd21);
  endtask

  task automatic test_illegal();
    step("illegal", 1'b1, 18'h00001, 32'd2, 32'd3, 32'd5, 1'b1, 1'b1, 5'd5);
    step("illegal_no_we", 1'b1, 18'h00020, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b1, 5'd31);
  endtask

  task automatic test_back_to_back();
    logic [31:0] specials[6];
    logic [17:0] op;
    logic [31:0] a;
    logic [31:0] b;
    int          r;
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3};
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(19, 0);
      if (r < 18)       op = 18'd1 << r;
      else if (r == 18) op = 18'd0;
      else              op = (18'd1 << $urandom_range(8, 0)) | (18'd1 << $urandom_range(17, 9));
      a = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
      b = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(5, 0)] : $urandom;
      step("random", 1'b1, op, a, b, alu_model(op, a, b),
           1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)));
    end
  endtask

  task automatic test_reset_midstream();
    step("pre_reset",  1'b1, 18'h00001, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0, 5'd7);
    step("mid_reset",  1'b0, 18'h00001, 32'd4, 32'd5, 32'd0, 1'b1, 1'b0, 5'd8);
    step("post_reset", 1'b1, 18'h00000, 32'd4, 32'd5, 32'd0, 1'b1, 1'b0, 5'd9);
    step("resume",     1'b1, 18'h00200, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b1, 1'b0, 5'd10);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shift_compare();
    test_mul();
    test_div();
    test_invalid_op();
    test_illegal();
    test_back_to_back();
    test_reset_midstream();
    step("drain", 1'b1, 18'h00000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
